// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS memory-access stage.
// Access sizes, FSM states and the default bus timeout.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mem_state_e;

    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port of the memory-access stage.
// master: the pipeline stage; slave: the memory or bus bridge.
interface mem_access_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/mem_access_stage_load_formatter.sv
// load_formatter: lane select and sign/zero extension of load data.
// Only built when MEM_SUBWORD_EN is defined.
`ifdef MEM_SUBWORD_EN
module load_formatter
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = rdata[{addr_lo, 3'b000} +: 8];
        h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data = rdata;
        unique case (size)
            SZ_BYTE: data = is_unsigned ? {24'b0, b}
                                        : {{24{b[7]}}, b};
            SZ_HALF: data = is_unsigned ? {16'b0, h}
                                        : {{16{h[15]}}, h};
            default: data = rdata;
        endcase
    end

endmodule
`endif

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: load/store to a req/ack data port, stalling.
// Define MEM_SUBWORD_EN for byte/halfword accesses; otherwise word only.
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_W           = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        RegWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemUnsignedM,
    output logic [31:0] ReadDataM,
    output logic        RegWriteOutM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    mem_access_stage_if.master dmem
);

    mem_state_e state_q, state_d;
    logic           req_q, req_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic           err_q, err_d;

    logic        mem_op;
    logic        misal;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_data;

    assign mem_op = MemReadM | MemWriteM;

`ifdef MEM_SUBWORD_EN
    mem_size_e sz;
    assign sz = mem_size_e'(MemSizeM);

    always_comb begin
        st_wdata = WriteDataM;
        st_be    = 4'b1111;
        misal    = |ALUOutM[1:0];
        unique case (sz)
            SZ_BYTE: begin
                st_wdata = {4{WriteDataM[7:0]}};
                st_be    = 4'b0001 << ALUOutM[1:0];
                misal    = 1'b0;
            end
            SZ_HALF: begin
                st_wdata = {2{WriteDataM[15:0]}};
                st_be    = ALUOutM[1] ? 4'b1100 : 4'b0011;
                misal    = ALUOutM[0];
            end
            default: misal = |ALUOutM[1:0];
        endcase
    end

    load_formatter u_fmt (
        .rdata       (rdata_q),
        .addr_lo     (ALUOutM[1:0]),
        .size        (sz),
        .is_unsigned (MemUnsignedM),
        .data        (ld_data)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{MemSizeM, MemUnsignedM};
    assign st_wdata   = WriteDataM;
    assign st_be      = 4'b1111;
    assign misal      = |ALUOutM[1:0];
    assign ld_data    = rdata_q;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        StallM       = 1'b0;
        RegWriteOutM = RegWriteM;
        ReadDataM    = '0;
        MisalignM    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_op && misal) begin
                    MisalignM    = 1'b1;
                    RegWriteOutM = 1'b0;
                end else if (mem_op) begin
                    StallM       = 1'b1;
                    RegWriteOutM = 1'b0;
                    req_d        = 1'b1;
                    we_d         = MemWriteM;
                    addr_d       = {ALUOutM[31:2], 2'b00};
                    wdata_d      = st_wdata;
                    be_d         = st_be;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                StallM       = 1'b1;
                RegWriteOutM = 1'b0;
                // Ack takes priority over a timeout in the same cycle
                if (dmem.dmem_ack) begin
                    rdata_d = dmem.dmem_rdata;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (err_q) begin
                    RegWriteOutM = 1'b0;
                end else if (MemReadM) begin
                    ReadDataM = ld_data;
                end
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign BusErrM = (state_q == DONE) & err_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, scoreboard, corner sequences.
// Expectations follow MEM_SUBWORD_EN when it is defined.
module tb_mem_access_stage;
    import mips_mem_pkg::*;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        RegWriteM = 1'b0;
    logic [1:0]  MemSizeM = 2'b10;
    logic        MemUnsignedM = 1'b0;
    logic [31:0] ReadDataM;
    logic        RegWriteOutM;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;

    mem_access_stage_if dmem_bus();

    mem_access_stage #(
        .TIMEOUT_CYCLES (TMO),
        .TO_W           (8)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .ALUOutM      (ALUOutM),
        .WriteDataM   (WriteDataM),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .RegWriteM    (RegWriteM),
        .MemSizeM     (MemSizeM),
        .MemUnsignedM (MemUnsignedM),
        .ReadDataM    (ReadDataM),
        .RegWriteOutM (RegWriteOutM),
        .StallM       (StallM),
        .MisalignM    (MisalignM),
        .BusErrM      (BusErrM),
        .dmem         (dmem_bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        rw;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        e_mis;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_rd;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        rwo;
        logic        berr;
    } exp_t;

    vec_t tbl[13];
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic vec_t mk(
        logic rd, logic wr, logic rw, logic [1:0] sz, logic uns,
        logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
        int lat, logic mis, logic [31:0] eaddr,
        logic [31:0] ewdata, logic [3:0] ebe, logic [31:0] erd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rw = rw; v.sz = sz; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.lat = lat;
        v.e_mis = mis; v.e_addr = eaddr; v.e_wdata = ewdata;
        v.e_be = ebe; v.e_rd = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        MemReadM     = 1'b0;
        MemWriteM    = 1'b0;
        RegWriteM    = 1'b0;
        MemSizeM     = 2'b10;
        MemUnsignedM = 1'b0;
        ALUOutM      = '0;
        WriteDataM   = '0;
        dmem_bus.dmem_ack = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t  e;
        int    stalls;
        bit    done;
        bit    rwo_bad;
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge CLK);
        MemReadM     = v.rd;
        MemWriteM    = v.wr;
        RegWriteM    = v.rw;
        MemSizeM     = v.sz;
        MemUnsignedM = v.uns;
        ALUOutM      = v.addr;
        WriteDataM   = v.wdata;
        dmem_bus.dmem_ack = 1'b0;
        #1;
        if (!(v.rd || v.wr)) begin
            chk({nm, ".pass_stall"}, 32'(StallM), 32'd0);
            chk({nm, ".pass_rwo"}, 32'(RegWriteOutM), 32'(v.rw));
            chk({nm, ".pass_rdata"}, ReadDataM, 32'd0);
            chk({nm, ".pass_mis"}, 32'(MisalignM), 32'd0);
        end else if (v.e_mis) begin
            chk({nm, ".mis"}, 32'(MisalignM), 32'd1);
            chk({nm, ".mis_stall"}, 32'(StallM), 32'd0);
            chk({nm, ".mis_rwo"}, 32'(RegWriteOutM), 32'd0);
            @(negedge CLK);
            #1;
            chk({nm, ".mis_noreq"}, 32'(dmem_bus.dmem_req), 32'd0);
        end else begin
            chk({nm, ".idle_stall"}, 32'(StallM), 32'd1);
            chk({nm, ".idle_rwo"}, 32'(RegWriteOutM), 32'd0);
            chk({nm, ".idle_mis"}, 32'(MisalignM), 32'd0);
            e.rd   = v.rd ? v.e_rd : 32'd0;
            e.rwo  = v.rw;
            e.berr = 1'b0;
            sbq.push_back(e);
            stalls  = 1;
            done    = 1'b0;
            rwo_bad = 1'b0;
            for (int c = 0; c < TMO + 4 && !done; c++) begin
                @(negedge CLK);
                dmem_bus.dmem_ack   = (c == v.lat);
                dmem_bus.dmem_rdata = (c == v.lat) ? v.rdata : $urandom;
                #1;
                if (c == 0) begin
                    chk({nm, ".req"}, 32'(dmem_bus.dmem_req), 32'd1);
                    chk({nm, ".we"}, 32'(dmem_bus.dmem_we), 32'(v.wr));
                    chk({nm, ".addr"}, dmem_bus.dmem_addr, v.e_addr);
                    chk({nm, ".be"}, 32'(dmem_bus.dmem_be), 32'(v.e_be));
                    chk({nm, ".wdata"}, dmem_bus.dmem_wdata, v.e_wdata);
                end
                if (StallM) begin
                    stalls++;
                    if (RegWriteOutM) rwo_bad = 1'b1;
                end else begin
                    done = 1'b1;
                    e = sbq.pop_front();
                    chk({nm, ".rdata"}, ReadDataM, e.rd);
                    chk({nm, ".rwo"}, 32'(RegWriteOutM), 32'(e.rwo));
                    chk({nm, ".buserr"}, 32'(BusErrM), 32'(e.berr));
                end
            end
            dmem_bus.dmem_ack = 1'b0;
            chk({nm, ".completed"}, 32'(done), 32'd1);
            chk({nm, ".stalls"}, 32'(stalls), 32'(v.lat + 2));
            chk({nm, ".stall_rwo"}, 32'(rwo_bad), 32'd0);
        end
        idle_in();
    endtask

    initial begin : main
        int reqs;
        int stalls;
        bit done;
        exp_t e;

`ifdef MEM_SUBWORD_EN
        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 'h100, 0, 'hDEADBEEF, 0,
                     1'b0, 'h100, 0, 4'hF, 'hDEADBEEF);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 'h203, 'hA5, 'h11111111, 1,
                     1'b0, 'h200, 'hA5A5A5A5, 4'h8, 0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 'h202, 0, 'h12F45678, 0,
                     1'b0, 'h200, 0, 4'h4, 'hFFFFFFF4);
        tbl[3]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 'h202, 0, 'h12F45678, 2,
                     1'b0, 'h200, 0, 4'h4, 'h000000F4);
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 'h102, 0, 0, 0,
                     1'b1, 0, 0, 4'h0, 0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 'h106, 0, 'h80011234, 3,
                     1'b0, 'h104, 0, 4'hC, 'hFFFF8001);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 'h104, 0, 'h80011234, 1,
                     1'b0, 'h104, 0, 4'h3, 'h00001234);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 'h20C, 'hCAFEF00D,
                     'h22222222, 2, 1'b0, 'h20C, 'hCAFEF00D, 4'hF, 0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 'h20E, 'h0000BEEF, 0, 0,
                     1'b0, 'h20C, 'hBEEFBEEF, 4'hC, 0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 'h101, 0, 0, 0,
                     1'b1, 0, 0, 4'h0, 0);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 'h201, 0, 'h12F45678, 1,
                     1'b0, 'h200, 0, 4'h2, 'h00000056);
`else
        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 'h100, 0, 'hDEADBEEF, 0,
                     1'b0, 'h100, 0, 4'hF, 'hDEADBEEF);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 'h203, 'hA5, 'h11111111, 1,
                     1'b1, 0, 0, 4'h0, 0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 'h202, 0, 'h12F45678, 0,
                     1'b1, 0, 0, 4'h0, 0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 'h202, 0, 'h12F45678, 2,
                     1'b1, 0, 0, 4'h0, 0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 'h102, 0, 0, 0,
                     1'b1, 0, 0, 4'h0, 0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 'h106, 0, 'h80011234, 3,
                     1'b1, 0, 0, 4'h0, 0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 'h104, 0, 'h80011234, 1,
                     1'b0, 'h104, 0, 4'hF, 'h80011234);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 'h20C, 'hCAFEF00D,
                     'h22222222, 2, 1'b0, 'h20C, 'hCAFEF00D, 4'hF, 0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 'h20E, 'h0000BEEF, 0, 0,
                     1'b1, 0, 0, 4'h0, 0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 'h101, 0, 0, 0,
                     1'b1, 0, 0, 4'h0, 0);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 'h201, 0, 'h12F45678, 1,
                     1'b1, 0, 0, 4'h0, 0);
`endif
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 'h123, 0, 0, 0,
                     1'b0, 0, 0, 4'h0, 0);
        tbl[11] = mk(1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 'h300, 0, 'h89ABCDEF, 0,
                     1'b0, 'h300, 0, 4'hF, 'h89ABCDEF);

        idle_in();
        dmem_bus.dmem_rdata = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst.req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rst.we", 32'(dmem_bus.dmem_we), 32'd0);
        chk("rst.addr", dmem_bus.dmem_addr, 32'd0);
        chk("rst.wdata", dmem_bus.dmem_wdata, 32'd0);
        chk("rst.be", 32'(dmem_bus.dmem_be), 32'd0);
        chk("rst.stall", 32'(StallM), 32'd0);
        chk("rst.rdata", ReadDataM, 32'd0);
        Reset = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

        // Timeout: no ack ever arrives
        @(negedge CLK);
        MemReadM = 1'b1;
        RegWriteM = 1'b1;
        ALUOutM = 32'h400;
        #1;
        e.rd = 32'd0;
        e.rwo = 1'b0;
        e.berr = 1'b1;
        sbq.push_back(e);
        reqs = 0;
        stalls = 1;
        done = 1'b0;
        for (int c = 0; c < TMO + 6 && !done; c++) begin
            @(negedge CLK);
            #1;
            if (dmem_bus.dmem_req) reqs++;
            if (StallM) stalls++;
            else begin
                done = 1'b1;
                e = sbq.pop_front();
                chk("to.buserr", 32'(BusErrM), 32'(e.berr));
                chk("to.rdata", ReadDataM, e.rd);
                chk("to.rwo", 32'(RegWriteOutM), 32'(e.rwo));
            end
        end
        chk("to.completed", 32'(done), 32'd1);
        chk("to.req_cycles", 32'(reqs), 32'(TMO));
        chk("to.stalls", 32'(stalls), 32'(TMO + 1));
        idle_in();
        @(negedge CLK);
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = 32'h55AA55AA;
        #1;
        chk("stray.buserr", 32'(BusErrM), 32'd0);
        @(negedge CLK);
        dmem_bus.dmem_ack = 1'b0;
        #1;
        chk("stray.req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("stray.stall", 32'(StallM), 32'd0);
        chk("stray.rdata", ReadDataM, 32'd0);

        // Reset asserted while waiting for ack
        @(negedge CLK);
        MemReadM = 1'b1;
        RegWriteM = 1'b1;
        ALUOutM = 32'h500;
        @(negedge CLK);
        #1;
        chk("rw.req_before", 32'(dmem_bus.dmem_req), 32'd1);
        #2;
        idle_in();
        Reset = 1'b0;
        #1;
        chk("rw.req_async", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rw.stall", 32'(StallM), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = 32'h0BADF00D;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rw.req%0d", c), 32'(dmem_bus.dmem_req), 32'd0);
            chk($sformatf("rw.rwo%0d", c), 32'(RegWriteOutM), 32'd0);
            chk($sformatf("rw.rd%0d", c), ReadDataM, 32'd0);
            @(negedge CLK);
            dmem_bus.dmem_ack = 1'b0;
        end

        run_vec(tbl[0], 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the pipelined MIPS core, between the EX/MEM pipeline register and the MEM/WB (write-back) register. Turns load/store control from EX/MEM into a registered request/acknowledge transaction on the data-memory port and stalls the pipeline until it completes. Produces the load data, and a write-enable forced to a bubble while stalled, for the write-back register.

## Interface
- TIMEOUT_CYCLES, 255: WAIT cycles without `dmem_ack` before the access is aborted as a bus error.
- TO_W, 8: timeout counter width; ≥ clog2(TIMEOUT_CYCLES+1).

- CLK  in  1  clock, rising edge.
- Reset  in  1  reset, asynchronous, active-low.
- ALUOutM  in  32  effective address.
- WriteDataM  in  32  store data.
- MemReadM  in  1  load.
- MemWriteM  in  1  store; never asserted together with MemReadM.
- RegWriteM  in  1  register write request from EX/MEM.
- MemSizeM  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- MemUnsignedM  in  1  zero-extend sub-word loads.
- ReadDataM  out  32  formatted load data to the write-back register.
- RegWriteOutM  out  1  write enable to the write-back register; 0 during stall, misalign, bus error.
- StallM  out  1  to hazard unit: freeze PC, IF/ID, ID/EX and EX/MEM.
- MisalignM  out  1  misaligned access flag.
- BusErrM  out  1  timeout abort flag.
- dmem_req  out  1  request, held until ack.
- dmem_we  out  1  1 store, 0 load.
- dmem_addr  out  32  word address, low two bits 00.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables; lane n = bits 8n+7:8n (little-endian).
- dmem_rdata  in  32  load data, valid with ack.
- dmem_ack  in  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, no memory op: pass-through. StallM=0, RegWriteOutM=RegWriteM, ReadDataM=0.
- IDLE, aligned op: StallM=1, RegWriteOutM=0. Latch addr, we, wdata, be into the dmem registers; dmem_req←1; go to WAIT.
- IDLE, misaligned op (half with addr[0]=1; word with addr[1:0]≠0):
  - MisalignM=1, StallM=0, RegWriteOutM=0.
  - No request issued; stays in IDLE.
- WAIT: StallM=1, RegWriteOutM=0, counter increments each cycle.
  - dmem_ack: capture dmem_rdata, dmem_req←0, go to DONE.
  - Counter reaches TIMEOUT_CYCLES: dmem_req←0, set error flag, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE (one cycle): StallM=0.
  - Normal: ReadDataM = formatted captured data (stores: 0); RegWriteOutM=RegWriteM.
  - Timeout: BusErrM=1, ReadDataM=0, RegWriteOutM=0.
  - EX/MEM advances at the end of the cycle; go to IDLE.
- dmem_ack outside WAIT is ignored.
- Store formatting:
  - SB: byte replicated to all lanes, be = 1<<addr[1:0].
  - SH: half replicated, be = addr[1] ? 1100 : 0011.
  - SW: be = 1111.
- Load formatting: select lane(s) by addr[1:0], then sign- or zero-extend per MemUnsignedM.

## Timing
- Reset values: state IDLE, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, dmem_be 0, captured data 0, counter 0, error flag 0.
- ReadDataM, StallM, RegWriteOutM and MisalignM are combinational from state and inputs. BusErrM is valid only in DONE.
- Minimum access: 3 cycles (IDLE, WAIT with ack, DONE), of which 2 are stall cycles.
- Each extra cycle of ack latency adds one stall cycle.
- Worst case: TIMEOUT_CYCLES+2 cycles.
- Reset mid-transaction: immediate return to IDLE, dmem_req drops asynchronously, transaction abandoned, a late ack is ignored.

## Configuration
- MEM_SUBWORD_EN defined:
  - Byte and halfword loads/stores as above.
  - Halfword alignment check applies.
- Undefined:
  - Word accesses only; MemSizeM and MemUnsignedM ignored.
  - dmem_be = 1111; ReadDataM = raw captured word.
  - Only addr[1:0]≠0 flags misalign.

## Structure
- Shared package mips_mem_pkg: MemSizeM encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encodings, default TIMEOUT_CYCLES.
- Sub-module load_formatter: combinational lane select plus sign/zero extension. Compiled only under MEM_SUBWORD_EN.

## Test plan
- LW from 0x100, ack one cycle after req, rdata 0xDEADBEEF -> StallM high exactly 2 cycles; DONE cycle ReadDataM=0xDEADBEEF, RegWriteOutM=1.
- SB of 0x000000A5 to 0x203 -> dmem_addr 0x200, be 1000, wdata 0xA5A5A5A5, we 1; RegWriteOutM=0 throughout.
- LB 0x202 and LBU 0x202, rdata 0x12F45678 -> ReadDataM 0xFFFFFFF4 and 0x000000F4.
- LW from 0x102 -> MisalignM=1 same cycle, no dmem_req, StallM=0, RegWriteOutM=0.
- TIMEOUT_CYCLES=4, no ack -> dmem_req high 4 cycles, DONE with BusErrM=1, ReadDataM=0; a later stray ack is ignored.
- Reset low during WAIT, then ack -> dmem_req 0 immediately, state IDLE, no DONE, no RegWriteOutM pulse.
